// File: rtl/ben_at_uvu_combo_lock_pkg.sv
// Shared types, constants and small helpers for the keypad combination lock.
package ben_combo_pkg;

    typedef enum logic [1:0] {
        PROGRAM  = 2'd0,
        LOCKED   = 2'd1,
        UNLOCKED = 2'd2
    } state_t;

    typedef logic [3:0] key_t;

    localparam int          COMBO_LEN = 4;
    localparam logic [3:0]  SCAN_INIT = 4'b0001;

    // Index of the lowest set bit; bit 0 wins when several rows are active.
    function automatic logic [1:0] lowest_set_bit(input logic [3:0] vec);
        logic [1:0] idx;
        casez (vec)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Index of the single set bit of a one-hot column drive.
    function automatic logic [1:0] onehot_index(input logic [3:0] vec);
        logic [1:0] idx;
        case (vec)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ben_at_uvu_combo_lock_scanner.sv
// Keypad column scanner: rotates the column drive, decodes the row return of
// the active column into a key code and debounces a held key so it is
// reported once until the pad has been idle for a full sweep.
module ben_keypad_scanner
    import ben_combo_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_code,
    output logic [3:0] o_scan,
    output logic       o_key_valid,
    output key_t       o_key
);

    logic [3:0] r_scan;
    logic       r_held;
    logic [1:0] r_rel_cnt;
    logic       w_any_row;

    assign w_any_row = (i_code != 4'b0000);

    // Column rotation plus held/release tracking; idle edges are counted only while held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan    <= SCAN_INIT;
            r_held    <= 1'b0;
            r_rel_cnt <= 2'd0;
        end else begin
            r_scan <= {r_scan[2:0], r_scan[3]};
            if (w_any_row) begin
                r_held    <= 1'b1;
                r_rel_cnt <= 2'd0;
            end else if (r_held) begin
                if (r_rel_cnt == 2'd3) begin
                    r_held    <= 1'b0;
                    r_rel_cnt <= 2'd0;
                end else begin
                    r_held    <= 1'b1;
                    r_rel_cnt <= r_rel_cnt + 2'd1;
                end
            end else begin
                r_held    <= 1'b0;
                r_rel_cnt <= 2'd0;
            end
        end
    end

    // Key decode from the column being driven this cycle and the lowest active row.
    always_comb begin
        o_key_valid = 1'b0;
        o_key       = 4'h0;
        if (w_any_row && !r_held) begin
            o_key_valid = 1'b1;
            o_key       = {onehot_index(r_scan), lowest_set_bit(i_code)};
        end else begin
            o_key_valid = 1'b0;
            o_key       = 4'h0;
        end
    end

    assign o_scan = r_scan;

endmodule

// File: rtl/ben_at_uvu_combo_lock.sv
// 4x4 keypad combination lock: programs a 4-key combination after a master
// reset, then releases the lock when the same 4 keys are entered in order.
module ben_at_uvu_combo_lock
    import ben_combo_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic       w_clk;
    logic       w_rst;
    logic       w_mrst;
    logic [3:0] w_code;
    logic       w_unused;

    logic [3:0] w_scan;
    logic       w_key_valid;
    key_t       w_key;

    state_t     r_state;
    key_t       r_slot [COMBO_LEN];
    logic [1:0] r_count;
    logic       r_mismatch;
    logic       r_unlock;

    localparam logic [1:0] LAST_IDX = 2'(COMBO_LEN - 1);

    assign w_code   = io_in[3:0];
    assign w_rst    = io_in[4];
    assign w_mrst   = io_in[5];
    assign w_clk    = io_in[6];
    assign w_unused = io_in[7];

    ben_keypad_scanner u_scanner (
        .i_clk       (w_clk),
        .i_rst       (w_rst | w_mrst),
        .i_code      (w_code),
        .o_scan      (w_scan),
        .o_key_valid (w_key_valid),
        .o_key       (w_key)
    );

    // Lock FSM: programming, checking entered keys against the slots, and the unlock flag.
    always_ff @(posedge w_clk) begin
        if (w_mrst) begin
            r_state    <= PROGRAM;
            r_count    <= 2'd0;
            r_mismatch <= 1'b0;
            r_unlock   <= 1'b0;
            for (int i = 0; i < COMBO_LEN; i++) begin
                r_slot[i] <= 4'h0;
            end
        end else if (w_rst) begin
            r_state    <= (r_state == PROGRAM) ? PROGRAM : LOCKED;
            r_count    <= 2'd0;
            r_mismatch <= 1'b0;
            r_unlock   <= 1'b0;
        end else begin
            case (r_state)
                PROGRAM: begin
                    r_unlock <= 1'b0;
                    if (w_key_valid) begin
                        r_slot[r_count] <= w_key;
                        if (r_count == LAST_IDX) begin
                            r_state <= LOCKED;
                            r_count <= 2'd0;
                        end else begin
                            r_count <= r_count + 2'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_key_valid) begin
                        if (r_count == LAST_IDX) begin
                            r_count    <= 2'd0;
                            r_mismatch <= 1'b0;
                            // The last key's comparison is folded in here so unlock rises on its edge.
                            if (!r_mismatch && (w_key == r_slot[r_count])) begin
                                r_state  <= UNLOCKED;
                                r_unlock <= 1'b1;
                            end else begin
                                r_state  <= LOCKED;
                                r_unlock <= 1'b0;
                            end
                        end else begin
                            r_count    <= r_count + 2'd1;
                            r_mismatch <= r_mismatch | (w_key != r_slot[r_count]);
                            r_unlock   <= 1'b0;
                        end
                    end else begin
                        r_unlock <= 1'b0;
                    end
                end
                UNLOCKED: begin
                    r_unlock <= 1'b1;
                end
                default: begin
                    r_state    <= PROGRAM;
                    r_count    <= 2'd0;
                    r_mismatch <= 1'b0;
                    r_unlock   <= 1'b0;
                end
            endcase
        end
    end

    assign io_out = {3'b000, r_unlock, w_scan};

endmodule

// File: tb/tb_ben_at_uvu_combo_lock.sv
// Self-checking bench for the combination lock: directed scenarios followed by
// randomized key presses and resets, all compared against a queue-based model.
module tb_ben_at_uvu_combo_lock;

    logic       clk;
    logic       rst;
    logic       mrst;
    logic [3:0] code;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_checks;
    int n_errors;

    // Reference model: combination and entry as key lists, plus lock mode.
    localparam int M_PROG = 0;
    localparam int M_LOCK = 1;
    localparam int M_OPEN = 2;
    int   combo[$];
    int   entered[$];
    int   mode;
    logic exp_unlock;
    int   sc_idx;

    assign io_in = {1'b0, clk, mrst, rst, code};

    ben_at_uvu_combo_lock dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and compare scan and unlock with the model.
    task automatic tick();
        logic       r;
        logic [3:0] scan_exp;
        r = rst | mrst;
        @(posedge clk);
        #1;
        sc_idx   = r ? 0 : (sc_idx + 1) % 4;
        scan_exp = 4'b0001 << sc_idx;
        check_val("scan", {4'h0, io_out[3:0]}, {4'h0, scan_exp});
        check_val("unlock", {7'h0, io_out[4]}, {7'h0, exp_unlock});
    endtask

    function automatic void model_key(input int k);
        bit same;
        case (mode)
            M_PROG: begin
                combo.push_back(k);
                if (combo.size() == 4) mode = M_LOCK;
            end
            M_LOCK: begin
                entered.push_back(k);
                if (entered.size() == 4) begin
                    same = 1'b1;
                    for (int i = 0; i < 4; i++) if (entered[i] != combo[i]) same = 1'b0;
                    if (same) begin
                        mode       = M_OPEN;
                        exp_unlock = 1'b1;
                    end
                    entered.delete();
                end
            end
            default: ;
        endcase
    endfunction

    // Press key k (held for nsweeps sweeps), extra row bits above the true row are random.
    task automatic press(input int k, input int nsweeps);
        int         col;
        int         row;
        logic [3:0] val;
        logic [3:0] upper;
        col   = k / 4;
        row   = k % 4;
        upper = 4'hF << (row + 1);
        val   = (4'b0001 << row) | (4'($urandom) & upper);
        for (int w = 0; w < 4 && sc_idx != col; w++) tick();
        for (int s = 0; s < nsweeps; s++) begin
            code = val;
            if (s == 0) model_key(k);
            tick();
            code = 4'h0;
            if (s < nsweeps - 1) begin
                for (int z = 0; z < 3; z++) tick();
            end
        end
        code = 4'h0;
        for (int z = 0; z < 4 + $urandom_range(0, 2); z++) tick();
    endtask

    task automatic press4(input int a, input int b, input int c, input int d);
        press(a, 1);
        press(b, 1);
        press(c, 1);
        press(d, 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        if (mode == M_PROG) combo.delete();
        else mode = M_LOCK;
        entered.delete();
        exp_unlock = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_mrst();
        mrst = 1'b1;
        combo.delete();
        entered.delete();
        mode       = M_PROG;
        exp_unlock = 1'b0;
        tick();
        mrst = 1'b0;
    endtask

    initial begin
        int op;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        mrst       = 1'b0;
        code       = 4'h0;
        sc_idx     = 0;
        exp_unlock = 1'b0;
        mode       = M_PROG;

        // 1. master reset and scan rotation
        #2;
        pulse_mrst();
        check_val("t1_scan0", {4'h0, io_out[3:0]}, 8'h01);
        check_val("t1_tied", {5'h0, io_out[7:5]}, 8'h00);
        tick();
        check_val("t1_scan1", {4'h0, io_out[3:0]}, 8'h02);
        tick();
        check_val("t1_scan2", {4'h0, io_out[3:0]}, 8'h04);
        tick();
        check_val("t1_scan3", {4'h0, io_out[3:0]}, 8'h08);
        tick();
        check_val("t1_scan4", {4'h0, io_out[3:0]}, 8'h01);

        // 2. program 3,6,9,C then enter it
        press4(3, 6, 9, 12);
        check_val("t2_locked", {7'h0, io_out[4]}, 8'h00);
        press(3, 1);
        press(6, 1);
        press(9, 1);
        for (int w = 0; w < 4 && sc_idx != 3; w++) tick();
        code = 4'b0001;
        model_key(12);
        tick();
        code = 4'h0;
        check_val("t2_unlock_edge", {7'h0, io_out[4]}, 8'h01);
        for (int z = 0; z < 4; z++) tick();

        // 3. wrong last key, then right sequence
        pulse_rst();
        check_val("t3_relock", {7'h0, io_out[4]}, 8'h00);
        press4(3, 6, 9, 13);
        check_val("t3_wrong", {7'h0, io_out[4]}, 8'h00);
        press4(3, 6, 9, 12);
        check_val("t3_right", {7'h0, io_out[4]}, 8'h01);

        // 4. reset while unlocked keeps the combination
        pulse_rst();
        check_val("t4_rst", {7'h0, io_out[4]}, 8'h00);
        press4(3, 6, 9, 12);
        check_val("t4_again", {7'h0, io_out[4]}, 8'h01);

        // 5. a key held across sweeps counts once
        pulse_rst();
        press(3, 3);
        press(6, 1);
        press(9, 1);
        press(12, 1);
        check_val("t5_hold_once", {7'h0, io_out[4]}, 8'h01);

        // 6. master reset mid-entry, reprogram 1,1,1,1
        pulse_rst();
        press(3, 1);
        press(6, 1);
        pulse_mrst();
        press4(1, 1, 1, 1);
        press4(3, 6, 9, 12);
        check_val("t6_old_combo", {7'h0, io_out[4]}, 8'h00);
        press4(1, 1, 1, 1);
        check_val("t6_new_combo", {7'h0, io_out[4]}, 8'h01);

        // Randomized operation mix
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 99);
            if (op < 8) begin
                pulse_rst();
            end else if (op < 12) begin
                pulse_mrst();
            end else if (op < 40 && mode == M_LOCK && entered.size() == 0) begin
                for (int i = 0; i < 4; i++) press(combo[i], 1);
            end else begin
                press($urandom_range(0, 15), ($urandom_range(0, 4) == 0) ? 2 : 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
